// File: rtl/wb_bram_loader.sv
// Boot loader master: packs a byte stream big-endian into 32-bit words and writes
// each word with a single-beat Wishbone cycle to consecutive BRAM addresses.
module wb_bram_loader #(
   parameter logic [31:0] BASE_ADR = 32'h0000_0000,
   parameter int unsigned WORDS    = 2048,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        flush_i,
   input  logic [7:0]  in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   output logic        wb_we_o,
   input  logic        wb_ack_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [15:0] words_o
);
   localparam int unsigned       TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [15:0]       WORDS_LIM = 16'(WORDS);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       cnt, cnt_nxt;
   logic             flush_pend, flush_pend_nxt;
   logic [TMO_W-1:0] tmo, tmo_nxt;
   logic [31:0]      adr_nxt, dat_nxt;
   logic [3:0]       sel_nxt;
   logic [15:0]      words_nxt;
   logic             err_nxt;
   logic             take;
   logic [2:0]       fill;

   // in_ready_o is high exactly while in COLLECT, so a transfer implies COLLECT
   assign take = in_valid_i & in_ready_o;
   assign fill = {1'b0, cnt} + {2'b00, take};

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      flush_pend_nxt = flush_pend;
      tmo_nxt        = tmo;
      adr_nxt        = wb_adr_o;
      dat_nxt        = wb_dat_o;
      sel_nxt        = wb_sel_o;
      words_nxt      = words_o;
      err_nxt        = err_o;
      unique case (state)
         IDLE, DONE: begin
            if (start_i) begin
               state_nxt      = COLLECT;
               cnt_nxt        = '0;
               flush_pend_nxt = 1'b0;
               dat_nxt        = '0;
               words_nxt      = '0;
               err_nxt        = 1'b0;
            end
         end
         COLLECT: begin
            if (take) begin
               case (cnt)
                  2'd0:    dat_nxt[31:24] = in_data_i;
                  2'd1:    dat_nxt[23:16] = in_data_i;
                  2'd2:    dat_nxt[15:8]  = in_data_i;
                  default: dat_nxt[7:0]   = in_data_i;
               endcase
            end
            // A byte arriving with flush is counted before the flush decision
            if (fill == 3'd4 || (flush_i && fill != 3'd0)) begin
               state_nxt      = WRITE;
               cnt_nxt        = '0;
               flush_pend_nxt = flush_i;
               tmo_nxt        = '0;
               adr_nxt        = BASE_ADR + {14'd0, words_o, 2'b00};
               case (fill)
                  3'd1:    sel_nxt = 4'b1000;
                  3'd2:    sel_nxt = 4'b1100;
                  3'd3:    sel_nxt = 4'b1110;
                  default: sel_nxt = 4'b1111;
               endcase
            end else if (flush_i) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt = fill[1:0];
            end
         end
         WRITE: begin
            if (wb_ack_i) begin
               words_nxt = words_o + 16'd1;
               dat_nxt   = '0;
               sel_nxt   = '0;
               state_nxt = (words_nxt == WORDS_LIM || flush_pend) ? DONE : COLLECT;
            end else if (TIMEOUT != 0 && tmo == TMO_LAST) begin
               err_nxt   = 1'b1;
               sel_nxt   = '0;
               state_nxt = DONE;
            end else begin
               tmo_nxt = tmo + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Every output is a register decoded from the next state
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         cnt        <= '0;
         flush_pend <= 1'b0;
         tmo        <= '0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         wb_sel_o   <= '0;
         words_o    <= '0;
         err_o      <= 1'b0;
         in_ready_o <= 1'b0;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         flush_pend <= flush_pend_nxt;
         tmo        <= tmo_nxt;
         wb_adr_o   <= adr_nxt;
         wb_dat_o   <= dat_nxt;
         wb_sel_o   <= sel_nxt;
         words_o    <= words_nxt;
         err_o      <= err_nxt;
         in_ready_o <= (state_nxt == COLLECT);
         wb_cyc_o   <= (state_nxt == WRITE);
         wb_stb_o   <= (state_nxt == WRITE);
         wb_we_o    <= (state_nxt == WRITE);
         busy_o     <= (state_nxt == COLLECT) || (state_nxt == WRITE);
         done_o     <= (state_nxt == DONE);
      end
   end
endmodule

// File: tb/tb_wb_bram_loader.sv
// Scoreboard bench for wb_bram_loader: random byte sessions against a word-level
// model, with a Wishbone slave/monitor that acks, stores into a BRAM image and checks.
module tb_wb_bram_loader;
   localparam logic [31:0] BASE    = 32'h0000_0100;
   localparam int          WORDS_P = 8;
   localparam int          TMO_P   = 4;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wr_t;

   logic        clk, rst_n, start, flush, in_valid, in_ready;
   logic [7:0]  in_data;
   logic [31:0] wb_adr, wb_dat;
   logic [3:0]  wb_sel;
   logic        wb_stb, wb_cyc, wb_we, ack, busy, done, err;
   logic [15:0] words;

   int          n_cmp = 0;
   int          n_bad = 0;
   bit          ack_en = 1;
   int          cyc_cycles = 0;

   logic [7:0]  stream_q[$];
   wr_t         exp_q[$];
   logic [31:0] exp_img[$];
   logic [31:0] mem [int];

   wb_bram_loader #(.BASE_ADR(BASE), .WORDS(WORDS_P), .TIMEOUT(TMO_P)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .wb_adr_o(wb_adr), .wb_dat_o(wb_dat), .wb_sel_o(wb_sel),
      .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_we_o(wb_we), .wb_ack_i(ack),
      .busy_o(busy), .done_o(done), .err_o(err), .words_o(words)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired, got no event, expected event", name);
   endtask

   // Word-level reference: chunk the consumed bytes into big-endian words
   function automatic void model_session(input bit flushed, output int n_words, output int n_cons);
      int len;
      len     = stream_q.size();
      n_cons  = (len < 4 * WORDS_P) ? len : 4 * WORDS_P;
      n_words = 0;
      exp_img.delete();
      for (int i = 0; i < n_cons; i += 4) begin
         int  nb;
         wr_t w;
         nb    = (n_cons - i < 4) ? n_cons - i : 4;
         if (nb < 4 && !flushed) break;
         w.adr = BASE + 32'(4 * n_words);
         w.dat = '0;
         w.sel = '0;
         for (int j = 0; j < nb; j++) begin
            w.dat[31 - 8 * j -: 8] = stream_q[i + j];
            w.sel[3 - j]           = 1'b1;
         end
         exp_q.push_back(w);
         exp_img.push_back(w.dat);
         n_words++;
      end
   endfunction

   // Wishbone slave + scoreboard monitor
   int          waitc = 0;
   int          delay = 0;
   bit          prev_ack = 0;
   logic [31:0] snap_adr, snap_dat, mw;
   logic [3:0]  snap_sel;
   int          idx;
   wr_t         e;

   initial begin
      ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ack = 1'b0; waitc = 0; prev_ack = 0;
         end else begin
            if (prev_ack) check("bus_gap_after_ack", 32'(wb_cyc | wb_stb), 32'd0);
            prev_ack = 0;
            if (wb_cyc && wb_stb) begin
               cyc_cycles++;
               check("we_during_cycle", 32'(wb_we), 32'd1);
               if (waitc == 0) begin
                  snap_adr = wb_adr; snap_dat = wb_dat; snap_sel = wb_sel;
               end else begin
                  check("adr_stable", wb_adr, snap_adr);
                  check("dat_stable", wb_dat, snap_dat);
                  check("sel_stable", 32'(wb_sel), 32'(snap_sel));
               end
               if (ack_en && waitc >= delay) begin
                  ack = 1'b1;
                  prev_ack = 1;
                  if (exp_q.size() == 0) begin
                     fail_bound("unexpected_write");
                  end else begin
                     e = exp_q.pop_front();
                     check("wr_adr", wb_adr, e.adr);
                     check("wr_dat", wb_dat, e.dat);
                     check("wr_sel", 32'(wb_sel), 32'(e.sel));
                  end
                  idx = int'((wb_adr - BASE) >> 2);
                  mw  = mem.exists(idx) ? mem[idx] : 32'd0;
                  for (int b = 0; b < 4; b++)
                     if (wb_sel[b]) mw[8 * b +: 8] = wb_dat[8 * b +: 8];
                  mem[idx] = mw;
               end else begin
                  waitc++;
               end
            end else begin
               ack = 1'b0;
               waitc = 0;
               delay = int'($urandom_range(0, 2));
            end
         end
      end
   end

   task automatic check_zero_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_adr"}, wb_adr, 32'd0);
      check({tag, "_dat"}, wb_dat, 32'd0);
      check({tag, "_sel"}, 32'(wb_sel), 32'd0);
      check({tag, "_stb"}, 32'(wb_stb), 32'd0);
      check({tag, "_cyc"}, 32'(wb_cyc), 32'd0);
      check({tag, "_we"}, 32'(wb_we), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_words"}, 32'(words), 32'd0);
   endtask

   task automatic pulse_start(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_start_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_start_busy"}, 32'(busy), 32'd1);
      check({tag, "_start_done"}, 32'(done), 32'd0);
      check({tag, "_start_err"}, 32'(err), 32'd0);
      check({tag, "_start_words"}, 32'(words), 32'd0);
   endtask

   task automatic send_stream(input bit flush_last, input bit rand_start, output int consumed);
      int guard;
      bit stop;
      consumed = 0;
      stop = 0;
      for (int i = 0; i < stream_q.size() && !stop; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            flush = 1'b0;
            if (rand_start && $urandom_range(0, 1) == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         in_data  = stream_q[i];
         in_valid = 1'b1;
         flush    = flush_last && (i == stream_q.size() - 1);
         guard    = 0;
         while (!in_ready && !stop) begin
            if (done) stop = 1;
            else if (guard == 50) begin
               fail_bound("in_ready_wait");
               stop = 1;
            end else begin
               @(negedge clk);
               guard++;
            end
         end
         if (!stop) begin
            @(negedge clk);
            consumed++;
         end
      end
      in_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic send_flush();
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) fail_bound("flush_wait");
      else begin
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag);
      int guard = 0;
      while (!done && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!done) fail_bound({tag, "_done_wait"});
   endtask

   // mode 0: no flush, 1: flush after the stream, 2: flush with the last byte
   task automatic run_session(input string tag, input int mode, input bit rand_start);
      int exp_n, exp_cons, consumed;
      logic [31:0] rd;
      mem.delete();
      model_session(mode != 0, exp_n, exp_cons);
      pulse_start(tag);
      send_stream(mode == 2, rand_start, consumed);
      if (mode == 1 && consumed == stream_q.size()) send_flush();
      wait_done(tag);
      repeat (3) @(negedge clk);
      check({tag, "_consumed"}, 32'(consumed), 32'(exp_cons));
      check({tag, "_words"}, 32'(words), 32'(exp_n));
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
      for (int k = 0; k < exp_n; k++) begin
         rd = mem.exists(k) ? mem[k] : 32'hDEAD_BEEF;
         check({tag, "_readback"}, rd, exp_img[k]);
      end
   endtask

   task automatic random_stream(input int len);
      stream_q.delete();
      for (int i = 0; i < len; i++) stream_q.push_back(8'($urandom));
   endtask

   task automatic no_ack_prefix(input string tag);
      int consumed;
      ack_en = 0;
      random_stream(4);
      pulse_start(tag);
      cyc_cycles = 0;
      send_stream(1'b0, 1'b0, consumed);
      check({tag, "_consumed"}, 32'(consumed), 32'd4);
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero_outputs("idle");

      stream_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      run_session("two_words", 1, 1'b0);

      stream_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      run_session("partial_flush", 1, 1'b0);

      random_stream(4 * WORDS_P + 8);
      run_session("word_limit", 0, 1'b0);

      for (int s = 0; s < 4; s++) begin
         random_stream(int'($urandom_range(1, 24)));
         run_session($sformatf("rand%0d", s), int'($urandom_range(1, 2)), 1'b1);
      end

      no_ack_prefix("timeout");
      wait_done("timeout");
      @(negedge clk);
      check("timeout_cyc_cycles", 32'(cyc_cycles), 32'(TMO_P));
      check("timeout_err", 32'(err), 32'd1);
      check("timeout_done", 32'(done), 32'd1);
      check("timeout_words", 32'(words), 32'd0);
      check("timeout_cyc", 32'(wb_cyc), 32'd0);
      ack_en = 1;

      for (int s = 4; s < 7; s++) begin
         random_stream(int'($urandom_range(1, 24)));
         run_session($sformatf("rand%0d", s), int'($urandom_range(1, 2)), 1'b1);
      end

      no_ack_prefix("midrst");
      check("midrst_cyc_before", 32'(wb_cyc), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cyc_async", 32'(wb_cyc), 32'd0);
      check("midrst_stb_async", 32'(wb_stb), 32'd0);
      check("midrst_we_async", 32'(wb_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero_outputs("after_rst");
      ack_en = 1;

      random_stream(int'($urandom_range(5, 24)));
      run_session("post_reset", 2, 1'b1);

      check("final_pending_writes", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
